// File: rtl/vga_fill_arbiter.sv
// vga_fill_arbiter: round-robin share of the VGA pixel-write port between two filled-rectangle requesters.
// Optional macro VGA_CLIP_EN suppresses plot for pixels outside COLS x ROWS.
module vga_fill_arbiter #(
  parameter int nX   = 8,
  parameter int nY   = 7,
  parameter int COLS = 160,
  parameter int ROWS = 120
) (
  input  logic          CLOCK_50,
  input  logic          Resetn,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [nX-1:0] req0_x0,
  input  logic [nY-1:0] req0_y0,
  input  logic [nX-1:0] req0_w,
  input  logic [nY-1:0] req0_h,
  input  logic [23:0]   req0_color,
  input  logic [nX-1:0] req1_x0,
  input  logic [nY-1:0] req1_y0,
  input  logic [nX-1:0] req1_w,
  input  logic [nY-1:0] req1_h,
  input  logic [23:0]   req1_color,
  output logic [1:0]    done,
  output logic          busy,
  output logic [nX-1:0] VGA_X,
  output logic [nY-1:0] VGA_Y,
  output logic [23:0]   VGA_COLOR,
  output logic          plot
);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t state;
  logic g, last_grant, grant, accept, wrap, last_px, vis;
  logic [nX-1:0] x0, w, cx, nx_c, in_x0, in_w, xb, xo, px;
  logic [nY-1:0] y0, h, cy, ny_c, in_y0, in_h, yb, yo, py;
  logic [23:0] color, in_color;
`ifdef VGA_CLIP_EN
  localparam logic [nX:0] COLS_L = COLS[nX:0];
  localparam logic [nY:0] ROWS_L = ROWS[nY:0];
  logic x_carry, y_carry;
`endif
  // Grant/handshake, command mux, raster stepping and next pixel position.
  // The outputs lead the state by one edge: the acceptance edge already
  // registers pixel (0,0), and each DRAW edge registers the following pixel.
  always_comb begin
    grant = &req_valid ? ~last_grant : req_valid[1];
    req_ready = (Resetn && state == IDLE) ? req_valid & (grant ? 2'b10 : 2'b01) : 2'b00;
    accept = |req_ready;
    in_x0 = grant ? req1_x0 : req0_x0;
    in_y0 = grant ? req1_y0 : req0_y0;
    in_w = grant ? req1_w : req0_w;
    in_h = grant ? req1_h : req0_h;
    in_color = grant ? req1_color : req0_color;
    wrap = cx == w - nX'(1);
    last_px = wrap && cy == h - nY'(1);
    nx_c = wrap ? '0 : cx + nX'(1);
    ny_c = wrap ? cy + nY'(1) : cy;
    xb = accept ? in_x0 : x0;
    yb = accept ? in_y0 : y0;
    xo = accept ? '0 : nx_c;
    yo = accept ? '0 : ny_c;
`ifdef VGA_CLIP_EN
    {x_carry, px} = {1'b0, xb} + {1'b0, xo};
    {y_carry, py} = {1'b0, yb} + {1'b0, yo};
    vis = ({x_carry, px} < COLS_L) && ({y_carry, py} < ROWS_L);
`else
    px = xb + xo;
    py = yb + yo;
    vis = 1'b1;
`endif
  end
  // Arbiter FSM with registered pixel, done and busy outputs.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      g <= 1'b0;
      last_grant <= 1'b1;
      x0 <= '0;
      y0 <= '0;
      w <= '0;
      h <= '0;
      color <= '0;
      cx <= '0;
      cy <= '0;
      VGA_X <= '0;
      VGA_Y <= '0;
      VGA_COLOR <= '0;
      plot <= 1'b0;
      done <= 2'b00;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          g <= grant;
          x0 <= in_x0;
          y0 <= in_y0;
          w <= in_w;
          h <= in_h;
          color <= in_color;
          cx <= '0;
          cy <= '0;
          busy <= 1'b1;
          if (in_w == '0 || in_h == '0) begin
            state <= DONE;
            done <= grant ? 2'b10 : 2'b01;
          end else begin
            state <= DRAW;
            VGA_X <= px;
            VGA_Y <= py;
            VGA_COLOR <= in_color;
            plot <= vis;
          end
        end
        DRAW: if (last_px) begin
          state <= DONE;
          plot <= 1'b0;
          done <= g ? 2'b10 : 2'b01;
        end else begin
          cx <= nx_c;
          cy <= ny_c;
          VGA_X <= px;
          VGA_Y <= py;
          VGA_COLOR <= color;
          plot <= vis;
        end
        DONE: begin
          state <= IDLE;
          done <= 2'b00;
          busy <= 1'b0;
          last_grant <= g;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_fill_arbiter.sv
// tb_vga_fill_arbiter: table-driven scoreboard bench for vga_fill_arbiter.
module tb_vga_fill_arbiter;
  logic clk = 1'b0;
  logic Resetn;
  logic [1:0] req_valid, req_ready, done;
  logic [7:0] req0_x0, req1_x0, req0_w, req1_w, VGA_X;
  logic [6:0] req0_y0, req1_y0, req0_h, req1_h, VGA_Y;
  logic [23:0] req0_color, req1_color, VGA_COLOR;
  logic busy, plot;

  vga_fill_arbiter dut (
    .CLOCK_50(clk), .Resetn(Resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req0_x0(req0_x0), .req0_y0(req0_y0), .req0_w(req0_w), .req0_h(req0_h), .req0_color(req0_color),
    .req1_x0(req1_x0), .req1_y0(req1_y0), .req1_w(req1_w), .req1_h(req1_h), .req1_color(req1_color),
    .done(done), .busy(busy), .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .plot(plot)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [23:0] color;
    logic [1:0] done;
    logic busy;
  } obs_t;

  typedef struct {
    int r;
    int x0;
    int y0;
    int w;
    int h;
    logic [23:0] color;
  } cmd_t;

  obs_t exp_q[$];
  cmd_t tbl[7];
  cmd_t c;
  int checks = 0;
  int failures = 0;
  logic [7:0] lx;
  logic [6:0] ly;
  logic [23:0] lc;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  task automatic check_obs(input string n);
    obs_t e;
    e = exp_q.pop_front();
    checks++;
    if (plot !== e.plot || VGA_X !== e.x || VGA_Y !== e.y || VGA_COLOR !== e.color ||
        done !== e.done || busy !== e.busy || (e.busy && req_ready !== 2'b00)) begin
      failures++;
      $display("FAIL %s: got plot=%b x=%0d y=%0d c=%h done=%b busy=%b rdy=%b want plot=%b x=%0d y=%0d c=%h done=%b busy=%b",
               n, plot, VGA_X, VGA_Y, VGA_COLOR, done, busy, req_ready,
               e.plot, e.x, e.y, e.color, e.done, e.busy);
    end
  endtask

  task automatic push_cmd(input cmd_t k);
    obs_t o;
    for (int yy = 0; yy < k.h; yy++)
      for (int xx = 0; xx < k.w; xx++) begin
        int px;
        int py;
        px = k.x0 + xx;
        py = k.y0 + yy;
        lx = px[7:0];
        ly = py[6:0];
        lc = k.color;
`ifdef VGA_CLIP_EN
        o.plot = (px < 160) && (py < 120);
`else
        o.plot = 1'b1;
`endif
        o.x = lx;
        o.y = ly;
        o.color = lc;
        o.done = 2'b00;
        o.busy = 1'b1;
        exp_q.push_back(o);
      end
    o.plot = 1'b0;
    o.x = lx;
    o.y = ly;
    o.color = lc;
    o.done = k.r ? 2'b10 : 2'b01;
    o.busy = 1'b1;
    exp_q.push_back(o);
    o.done = 2'b00;
    o.busy = 1'b0;
    exp_q.push_back(o);
  endtask

  task automatic drive(input cmd_t k);
    if (k.r == 0) begin
      req0_x0 = 8'(k.x0); req0_y0 = 7'(k.y0); req0_w = 8'(k.w); req0_h = 7'(k.h); req0_color = k.color;
    end else begin
      req1_x0 = 8'(k.x0); req1_y0 = 7'(k.y0); req1_w = 8'(k.w); req1_h = 7'(k.h); req1_color = k.color;
    end
  endtask

  // Called just after a negedge with valid already raised.
  task automatic wait_ready(input int r, input string n);
    int cnt = 0;
    #1;
    while (req_ready == 2'b00 && cnt < 100) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    if (cnt >= 100) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got ready=%b want acceptance within 100 cycles", n, req_ready);
    end
    chk({n, "_ready"}, 64'(req_ready), r ? 64'd2 : 64'd1);
  endtask

  task automatic drain(input string n);
    while (exp_q.size() > 0) begin
      check_obs(n);
      if (exp_q.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic accept_now(input cmd_t k, input string n);
    push_cmd(k);
    @(posedge clk);
    #1;
    req_valid[k.r] = 1'b0;
    drain(n);
  endtask

  task automatic issue(input cmd_t k, input string n);
    @(negedge clk);
    drive(k);
    req_valid[k.r] = 1'b1;
    wait_ready(k.r, n);
    accept_now(k, n);
  endtask

  task automatic chk_zero(input string n);
    chk(n, {VGA_X, VGA_Y, VGA_COLOR, plot, done, busy, req_ready}, 64'd0);
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    req_valid = 2'b00;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    Resetn = 1'b1;
    lx = '0;
    ly = '0;
    lc = '0;
  endtask

  initial begin
    Resetn = 1'b0;
    req_valid = 2'b00;
    req0_x0 = '0; req0_y0 = '0; req0_w = '0; req0_h = '0; req0_color = '0;
    req1_x0 = '0; req1_y0 = '0; req1_w = '0; req1_h = '0; req1_color = '0;
    tbl[0] = '{0, 10, 5, 3, 2, 24'hFF0000};
    tbl[1] = '{1, 0, 0, 0, 5, 24'h00FF00};
    tbl[2] = '{0, 158, 0, 4, 1, 24'h0000FF};
    tbl[3] = '{0, 254, 0, 4, 1, 24'h123456};
    tbl[4] = '{1, 20, 118, 2, 3, 24'hABCDEF};
    tbl[5] = '{1, 100, 126, 1, 3, 24'h55AA55};
    tbl[6] = '{0, 5, 5, 0, 0, 24'h777777};
    do_reset();
    foreach (tbl[i]) issue(tbl[i], $sformatf("tbl%0d", i));

    // Reset in the middle of a 4x4 fill: abandon, no done, immediate accept afterwards.
    do_reset();
    c = '{0, 30, 40, 4, 4, 24'h0F0F0F};
    @(negedge clk);
    drive(c);
    req_valid = 2'b01;
    wait_ready(0, "midrst");
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midrst_px3", {plot, VGA_X, VGA_Y, VGA_COLOR}, {1'b1, 8'd32, 7'd40, 24'h0F0F0F});
    #5;
    req_valid = 2'b01;
    Resetn = 1'b0;
    #1;
    chk_zero("midrst_async");
    @(posedge clk);
    #1;
    chk_zero("midrst_held");
    @(negedge clk);
    Resetn = 1'b1;
    lx = '0;
    ly = '0;
    lc = '0;
    c = '{0, 50, 60, 2, 1, 24'h246802};
    drive(c);
    #1;
    chk("midrst_first_idle_ready", 64'(req_ready), 64'd1);
    accept_now(c, "midrst_new");

    // Round-robin with both requesters held valid.
    do_reset();
    begin
      cmd_t t[2];
      t[0] = '{0, 1, 1, 1, 1, 24'h000001};
      t[1] = '{1, 2, 2, 1, 1, 24'h000002};
      drive(t[0]);
      drive(t[1]);
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
        wait_ready(i % 2, $sformatf("rr%0d", i));
        push_cmd(t[i % 2]);
        @(posedge clk);
        #1;
        drain($sformatf("rr%0d", i));
        @(negedge clk);
      end
      req_valid = 2'b00;
    end

    // req0 raised while a req1 fill is drawing waits for IDLE.
    c = '{1, 60, 10, 4, 2, 24'hC0FFEE};
    @(negedge clk);
    drive(c);
    req_valid[1] = 1'b1;
    wait_ready(1, "pend1");
    push_cmd(c);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    c = '{0, 70, 20, 2, 2, 24'h112233};
    drive(c);
    req_valid[0] = 1'b1;
    drain("pend1");
    wait_ready(0, "pend0");
    accept_now(c, "pend0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
